// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (clk40 domain).
//
// Sends one command byte to the device over the open-drain ps2_clk/ps2_data pair.
// The lines are only ever pulled low through the *_oe enables; the top level builds
// the tristates (pin = oe ? 0 : Z).
//
// Frame sequence: inhibit (clock held low), request-to-send (data low, clock
// released), then the device clocks out 8 data bits, odd parity and stop on its
// falling clock edges. On fall 11 the device's acknowledge is sampled, and the
// block waits for the bus to go idle before reporting.
//
// Ports:
//   clk          system clock (clk40)
//   reset        synchronous, active-high reset
//   ps2_clk_in   raw ps2_clk pin level (asynchronous)
//   ps2_data_in  raw ps2_data pin level (asynchronous)
//   ps2_clk_oe   1 = pull ps2_clk low
//   ps2_data_oe  1 = pull ps2_data low
//   tx_data      command byte
//   tx_valid     request to send tx_data
//   tx_ready     high only when idle; transfer accepted on tx_valid & tx_ready
//   busy         high whenever a transfer is in progress
//   done         one-cycle pulse at the end of every accepted transfer
//   err          qualified by done: missing ACK or timeout
`timescale 1ns / 1ps
`default_nettype none

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 4000,
  parameter int unsigned RTS_CYCLES     = 40,
  parameter int unsigned TIMEOUT_CYCLES = 600000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned IrMax     = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned MaxCycles = (TIMEOUT_CYCLES > IrMax) ? TIMEOUT_CYCLES : IrMax;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] RtsLast     = CntW'(RTS_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StStart,
    StShift,
    StAck,
    StWaitIdle,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bitcnt_q;
  logic [9:0]      shift_q;
  logic            ack_err_q;
  logic            timeout_q;

  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            clk_prev_q;

  logic            fe;
  logic            bus_idle;
  logic            to_running;
  logic            to_fire;

  // Two-flop synchronisers plus one extra flop on clock for falling-edge detect.
  // Reset to the idle (released) level so no spurious edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fe       = clk_prev_q & ~clk_sync_q[1];
  assign bus_idle = clk_sync_q[1] & data_sync_q[1];

  // The gap timer runs only while the device owns the clock. A falling edge in
  // the terminal cycle wins, and so does reaching bus idle in StWaitIdle.
  assign to_running = (state_q == StStart) || (state_q == StShift) ||
                      (state_q == StAck)   || (state_q == StWaitIdle);
  assign to_fire    = to_running && (cnt_q == TimeoutLast) && !fe &&
                      !((state_q == StWaitIdle) && bus_idle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '1;
      ack_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (to_fire) begin
        // Device stopped clocking or never released the bus: give up.
        state_q     <= StDone;
        timeout_q   <= 1'b1;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        done        <= 1'b1;
        err         <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (tx_valid) begin
              // Frame as shifted out: bit0..7, odd parity, stop.
              shift_q    <= {1'b1, ~^tx_data, tx_data};
              ack_err_q  <= 1'b0;
              timeout_q  <= 1'b0;
              cnt_q      <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state_q    <= StInhibit;
            end
          end
          StInhibit: begin
            if (cnt_q == InhibitLast) begin
              cnt_q       <= '0;
              ps2_data_oe <= 1'b1;  // start bit
              state_q     <= StRts;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StRts: begin
            if (cnt_q == RtsLast) begin
              cnt_q      <= '0;
              ps2_clk_oe <= 1'b0;  // hand the clock to the device
              state_q    <= StStart;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StStart: begin
            if (fe) begin
              ps2_data_oe <= ~shift_q[0];
              bitcnt_q    <= 4'd1;
              cnt_q       <= '0;
              state_q     <= StShift;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StShift: begin
            if (fe) begin
              ps2_data_oe <= ~shift_q[bitcnt_q];
              bitcnt_q    <= bitcnt_q + 4'd1;
              cnt_q       <= '0;
              // bitcnt 9 is the stop bit, driven on fall 10.
              if (bitcnt_q == 4'd9) begin
                state_q <= StAck;
              end
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StAck: begin
            if (fe) begin
              ack_err_q <= data_sync_q[1];
              cnt_q     <= '0;
              state_q   <= StWaitIdle;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StWaitIdle: begin
            if (bus_idle) begin
              done    <= 1'b1;
              err     <= ack_err_q | timeout_q;
              state_q <= StDone;
            end else if (fe) begin
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StDone: begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
